// File: rtl/csa_accum_tree.sv
// csa_accum_tree
//   Pipelined 3:2 carry-save reduction of N_IN operands per beat, followed by a
//   single carry-propagate add into a group accumulator. A group is one or more
//   beats terminated by in_last; one registered result is emitted per group.
//
// Ports
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   beat valid
//   in_data    N_IN packed operands, operand j at [j*IN_W +: IN_W]
//   in_signed  group mode (1 = two's complement), taken from first beat only
//   in_last    final beat of group
//   out_valid  one-cycle result strobe
//   out_sum    group sum modulo 2^ACC_W
//   out_count  beats in group, saturating
//   out_ovf    group result left the ACC_W range in the group's mode
//   busy       group open or beats in flight
//
// Accumulator FSM
//   state  | meaning
//   S_IDLE | next valid beat at the accumulator starts a new group
//   S_OPEN | group in progress, acc/count/ovf hold partial results
module csa_accum_tree #(
  parameter int N_IN       = 8,
  parameter int IN_W       = 16,
  parameter int ACC_W      = 32,
  parameter int PIPE_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [N_IN*IN_W-1:0]   in_data,
  input  logic                   in_signed,
  input  logic                   in_last,
  output logic                   out_valid,
  output logic [ACC_W-1:0]       out_sum,
  output logic [CNT_W-1:0]       out_count,
  output logic                   out_ovf,
  output logic                   busy
);

  // Wide enough that the full N_IN-operand sum fits as a signed value in
  // either mode, so the tree can wrap freely modulo 2^TREE_W.
  localparam int TREE_W = IN_W + $clog2(N_IN) + 1;
  localparam int VW     = N_IN * TREE_W;

  function automatic int tree_levels(input int n);
    int m;
    int l;
    m = n;
    l = 0;
    while (m > 2) begin
      m = m - m / 3;
      l++;
    end
    return l;
  endfunction

  function automatic int cnt_after(input int lv);
    int m;
    m = N_IN;
    for (int i = 0; i < lv; i++) m = m - m / 3;
    return m;
  endfunction

  localparam int LEVELS = tree_levels(N_IN);

  // Register k (1..PIPE_DEPTH) sits after level ceil(k*LEVELS/PIPE_DEPTH);
  // the last one always lands after the final level.
  function automatic int regs_at(input int lv);
    int n;
    n = 0;
    for (int k = 1; k <= PIPE_DEPTH; k++)
      if (((k * LEVELS + PIPE_DEPTH - 1) / PIPE_DEPTH) == lv) n++;
    return n;
  endfunction

  // One row of 3:2 compressors over the first m slots; leftovers pass through.
  function automatic logic [VW-1:0] csa_level(input logic [VW-1:0] v, input int m);
    logic [VW-1:0]     r;
    logic [TREE_W-1:0] a, b, c;
    int                g;
    r = '0;
    g = m / 3;
    for (int i = 0; i < N_IN / 3; i++) begin
      if (i < g) begin
        a = v[(3*i)*TREE_W +: TREE_W];
        b = v[(3*i+1)*TREE_W +: TREE_W];
        c = v[(3*i+2)*TREE_W +: TREE_W];
        r[(2*i)*TREE_W +: TREE_W]   = a ^ b ^ c;
        r[(2*i+1)*TREE_W +: TREE_W] = ((a & b) | (a & c) | (b & c)) << 1;
      end
    end
    for (int i = 0; i < N_IN; i++)
      if (i >= 3 * g && i < m) r[(i-g)*TREE_W +: TREE_W] = v[i*TREE_W +: TREE_W];
    return r;
  endfunction

  // Input stage: resolve the group mode here so operands can be extended
  // before entering the tree.
  logic          in_open, in_mode, mode_res;
  logic [VW-1:0] ext_ops, s0_data;
  logic [2:0]    s0_ctrl;  // {mode, last, valid}

  always_comb begin
    mode_res = in_open ? in_mode : in_signed;
    ext_ops  = '0;
    for (int j = 0; j < N_IN; j++)
      ext_ops[j*TREE_W +: TREE_W] = {{(TREE_W-IN_W){mode_res & in_data[j*IN_W+IN_W-1]}},
                                     in_data[j*IN_W +: IN_W]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_ctrl <= '0;
      in_open <= 1'b0;
      in_mode <= 1'b0;
    end else begin
      s0_ctrl[0] <= in_valid;
      if (in_valid) begin
        s0_ctrl[2:1] <= {mode_res, in_last};
        in_open      <= !in_last;
        if (!in_open) in_mode <= in_signed;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) s0_data <= ext_ops;
  end

  // Tree levels with their register chains.
  logic [VW-1:0] node_data [LEVELS+1];
  logic [2:0]    node_ctrl [LEVELS+1];
  logic [LEVELS:0] lvl_busy;

  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int NR = regs_at(l);
    logic [VW-1:0] d [NR+1];
    logic [2:0]    c [NR+1];
    logic [NR:0]   vb;

    if (l == 0) begin : g_src
      assign d[0] = s0_data;
      assign c[0] = s0_ctrl;
    end else begin : g_csa
      assign d[0] = csa_level(node_data[l-1], cnt_after(l-1));
      assign c[0] = node_ctrl[l-1];
    end

    assign vb[0] = 1'b0;
    for (genvar k = 0; k < NR; k++) begin : g_reg
      logic [VW-1:0] q;
      logic [2:0]    qc;
      always_ff @(posedge clk) begin
        q <= d[k];
        if (!rst_n) qc <= '0;
        else        qc <= c[k];
      end
      assign d[k+1]  = q;
      assign c[k+1]  = qc;
      assign vb[k+1] = qc[0];
    end

    assign lvl_busy[l]  = |vb;
    assign node_data[l] = d[NR];
    assign node_ctrl[l] = c[NR];
  end

  // Accumulator stage.
  typedef enum logic {S_IDLE, S_OPEN} state_t;
  state_t state;

  logic [TREE_W-1:0] sum_t;
  logic [ACC_W-1:0]  acc, beat_sum, acc_base, acc_next;
  logic [CNT_W-1:0]  count, count_next;
  logic              carry, grp_mode, add_ovf, ovf_q, ovf_next, mode_q;
  logic              v_acc, last_acc, mode_acc;

  assign v_acc    = node_ctrl[LEVELS][0];
  assign last_acc = node_ctrl[LEVELS][1];
  assign mode_acc = node_ctrl[LEVELS][2];

  always_comb begin
    sum_t = '0;
    for (int i = 0; i < 2; i++) sum_t = sum_t + node_data[LEVELS][i*TREE_W +: TREE_W];
  end

  always_comb begin
    grp_mode = (state == S_OPEN) ? mode_q : mode_acc;
    beat_sum = grp_mode ? ACC_W'($signed(sum_t)) : ACC_W'(sum_t);
    acc_base = (state == S_OPEN) ? acc : '0;
    {carry, acc_next} = {1'b0, acc_base} + {1'b0, beat_sum};
    add_ovf  = grp_mode ? ((acc_base[ACC_W-1] == beat_sum[ACC_W-1]) &&
                           (acc_next[ACC_W-1] != acc_base[ACC_W-1]))
                        : carry;
    ovf_next = ((state == S_OPEN) & ovf_q) | add_ovf;
    if (state == S_IDLE)  count_next = CNT_W'(1);
    else if (&count)      count_next = count;
    else                  count_next = count + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      acc       <= '0;
      count     <= '0;
      ovf_q     <= 1'b0;
      mode_q    <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (v_acc) begin
        if (last_acc) begin
          out_valid <= 1'b1;
          out_sum   <= acc_next;
          out_count <= count_next;
          out_ovf   <= ovf_next;
          acc       <= '0;
          count     <= '0;
          ovf_q     <= 1'b0;
          state     <= S_IDLE;
        end else begin
          acc   <= acc_next;
          count <= count_next;
          ovf_q <= ovf_next;
          state <= S_OPEN;
          if (state == S_IDLE) mode_q <= mode_acc;
        end
      end
    end
  end

  assign busy = (state == S_OPEN) | s0_ctrl[0] | (|lvl_busy);

endmodule

// File: tb/tb_csa_accum_tree.sv
// Bench for csa_accum_tree: directed cases with hand-derived results, then
// random groups against an integer model of the group arithmetic. Expected
// results are queued at issue time and popped by monitors on out_valid.
module tb_csa_accum_tree;
  localparam int N  = 8;
  localparam int IW = 16;
  localparam int DW = N * IW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, in_valid2 = 1'b0;
  logic          in_signed = 1'b0, in_last = 1'b0;
  logic [DW-1:0] in_data = '0;

  logic          out_valid, out_ovf, busy;
  logic [31:0]   out_sum;
  logic [15:0]   out_count;
  logic          out_valid2, out_ovf2, busy2;
  logic [19:0]   out_sum2;
  logic [15:0]   out_count2;

  always #5 clk = ~clk;

  csa_accum_tree dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_signed(in_signed), .in_last(in_last), .out_valid(out_valid),
    .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf), .busy(busy)
  );

  csa_accum_tree #(.ACC_W(20)) dut20 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_data(in_data),
    .in_signed(in_signed), .in_last(in_last), .out_valid(out_valid2),
    .out_sum(out_sum2), .out_count(out_count2), .out_ovf(out_ovf2), .busy(busy2)
  );

  typedef struct {
    longint sum;
    int     cnt;
    bit     ovf;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state (32-bit instance, random phase).
  bit     use_model = 1'b0;
  bit     m_open = 1'b0, m_mode = 1'b0, m_ovf = 1'b0;
  longint m_acc = 0;
  int     m_cnt = 0;

  function automatic logic [DW-1:0] fill(input logic [15:0] v);
    logic [DW-1:0] r;
    for (int j = 0; j < N; j++) r[j*IW +: IW] = v;
    return r;
  endfunction

  function automatic logic [DW-1:0] ramp();
    logic [DW-1:0] r;
    for (int j = 0; j < N; j++) r[j*IW +: IW] = 16'(j);
    return r;
  endfunction

  function automatic longint op_val(input logic [DW-1:0] d, input int j, input bit s);
    logic [15:0] v;
    v = d[j*IW +: IW];
    return s ? longint'($signed(v)) : longint'(v);
  endfunction

  task automatic model_beat(input logic [DW-1:0] d, input bit s, input bit last);
    bit     mode, ovf;
    longint beat, base, exact, wrapped;
    int     cnt;
    mode = m_open ? m_mode : s;
    beat = 0;
    for (int j = 0; j < N; j++) beat += op_val(d, j, mode);
    base = 0;
    if (m_open) base = (mode && m_acc >= 64'sh8000_0000) ? m_acc - 64'sh1_0000_0000 : m_acc;
    exact = base + beat;
    if (mode) ovf = (exact < -64'sh8000_0000) || (exact > 64'sh7FFF_FFFF);
    else      ovf = (exact > 64'shFFFF_FFFF);
    wrapped = exact & 64'shFFFF_FFFF;
    cnt = m_open ? ((m_cnt >= 65535) ? 65535 : m_cnt + 1) : 1;
    ovf = ovf | (m_open & m_ovf);
    if (last) begin
      q0.push_back('{wrapped, cnt, ovf});
      m_open = 1'b0;
    end else begin
      m_open = 1'b1; m_mode = mode; m_acc = wrapped; m_cnt = cnt; m_ovf = ovf;
    end
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] d, input bit s, input bit l, input bit to2);
    @(negedge clk);
    in_valid  = v & ~to2;
    in_valid2 = v & to2;
    in_data   = d;
    in_signed = s;
    in_last   = l;
    if (v && rst_n && use_model && !to2) model_beat(d, s, l);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect0(input longint sum, input int cnt, input bit ovf);
    q0.push_back('{sum, cnt, ovf});
  endtask

  task automatic expect1(input longint sum, input int cnt, input bit ovf);
    q1.push_back('{sum, cnt, ovf});
  endtask

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin : mon0
    exp_t e;
    if (out_valid) begin
      tests++;
      if (q0.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out_valid: sum=%0h count=%0d (nothing expected)", out_sum, out_count);
      end else begin
        e = q0.pop_front();
        if (out_sum !== e.sum[31:0] || out_count !== e.cnt[15:0] || out_ovf !== e.ovf) begin
          fails++;
          $display("FAIL result: sum got %0h req %0h, count got %0d req %0d, ovf got %0b req %0b",
                   out_sum, e.sum[31:0], out_count, e.cnt, out_ovf, e.ovf);
        end
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (out_valid2) begin
      tests++;
      if (q1.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out_valid20: sum=%0h count=%0d", out_sum2, out_count2);
      end else begin
        e = q1.pop_front();
        if (out_sum2 !== e.sum[19:0] || out_count2 !== e.cnt[15:0] || out_ovf2 !== e.ovf) begin
          fails++;
          $display("FAIL result20: sum got %0d req %0d, count got %0d req %0d, ovf got %0b req %0b",
                   out_sum2, e.sum[19:0], out_count2, e.cnt, out_ovf2, e.ovf);
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] d;
    int nb;

    // Reset held three cycles with valid last beats on the input.
    in_valid = 1'b1; in_last = 1'b1; in_data = fill(16'hFFFF);
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    idle(6);
    check("post_rst_busy", busy, 0);

    // Unsigned single beat with latency and hold checks.
    drive(1, fill(16'hFFFF), 0, 1, 0);
    expect0(32'h0007FFF8, 1, 0);
    idle(3);
    check("lat_before", out_valid, 0);
    idle(1);
    check("lat_at", out_valid, 1);
    idle(1);
    check("pulse_width", out_valid, 0);
    check("hold_sum", out_sum, 32'h0007FFF8);
    check("hold_count", out_count, 1);

    // Signed single beat, then a 3-beat signed group with in_signed toggled.
    drive(1, fill(16'hFFFF), 1, 1, 0);
    expect0(32'hFFFFFFF8, 1, 0);
    drive(1, fill(16'hFFFF), 1, 0, 0);
    drive(1, fill(16'hFFFF), 0, 0, 0);
    drive(1, fill(16'hFFFF), 0, 1, 0);
    expect0(32'hFFFFFFE8, 3, 0);
    idle(5);

    // Multi-beat group with a bubble, then a back-to-back single beat.
    drive(1, ramp(), 0, 0, 0);
    drive(1, ramp(), 0, 0, 0);
    idle(1);
    drive(1, ramp(), 0, 0, 0);
    drive(1, ramp(), 0, 1, 0);
    expect0(112, 4, 0);
    drive(1, fill(16'h0001), 0, 1, 0);
    expect0(8, 1, 0);
    idle(6);

    // Overflow on the 20-bit instance, then a clean group.
    drive(1, fill(16'hFFFF), 0, 0, 1);
    drive(1, fill(16'hFFFF), 0, 0, 1);
    drive(1, fill(16'hFFFF), 0, 1, 1);
    expect1(524264, 3, 1);
    drive(1, fill(16'h0000), 0, 1, 1);
    expect1(0, 1, 0);
    idle(6);
    check("busy20_idle", busy2, 0);

    // Reset in the middle of a group.
    drive(1, ramp(), 0, 0, 0);
    drive(1, ramp(), 0, 0, 0);
    @(negedge clk);
    check("busy_mid_group", busy, 1);
    rst_n = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("busy_after_rst", busy, 0);
    check("valid_after_rst", out_valid, 0);
    rst_n = 1'b1;
    drive(1, fill(16'h0001), 0, 1, 0);
    expect0(8, 1, 0);
    idle(6);

    // Random groups against the model.
    use_model = 1'b1;
    for (int g = 0; g < 1000; g++) begin
      nb = $urandom_range(1, 5);
      for (int b = 0; b < nb; b++) begin
        if (b > 0 && $urandom_range(0, 3) == 0) idle(1);
        for (int j = 0; j < N; j++) begin
          case ($urandom_range(0, 5))
            0:       d[j*IW +: IW] = 16'hFFFF;
            1:       d[j*IW +: IW] = 16'h8000;
            2:       d[j*IW +: IW] = 16'h7FFF;
            default: d[j*IW +: IW] = 16'($urandom);
          endcase
        end
        drive(1, d, 1'($urandom_range(0, 1)), b == nb - 1, 0);
      end
    end
    idle(10);
    check("drain_q0", q0.size(), 0);
    check("drain_q1", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
